// File: rtl/play_ctrl_pkg.sv
// Shared types and defaults for the playback controller and its key debouncer.
package play_ctrl_pkg;

    localparam logic [15:0] DEBOUNCE_CNT_DEF = 16'h0351;
    localparam int          ADDR_W_DEF       = 22;

    typedef enum logic [1:0] {
        IDLE,
        ADDR_SET,
        WAIT_REQ,
        READ
    } play_state_e;

endpackage

// File: rtl/play_ctrl_if.sv
// Key, SDRAM read port and DAC signals of the playback controller.
// UNDERRUN_CNT_EN adds the underrun_cnt status output.
interface play_ctrl_if #(
    parameter int ADDR_W = play_ctrl_pkg::ADDR_W_DEF
) ();

    logic              key2;
    logic              rec_valid;
    logic [ADDR_W-1:0] rec_end_addr;
    logic              sample_req;
    logic              rd_req;
    logic              rd_ack;
    logic [15:0]       rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              sdr_raddr_set;
    logic              play_start;
    logic              playing;
    logic [15:0]       dac_data;
    logic              dac_valid;
`ifdef UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;
`endif

    modport master (
        input  key2, rec_valid, rec_end_addr, sample_req, rd_ack, rd_data,
        output rd_req, rd_addr, sdr_raddr_set, play_start, playing, dac_data, dac_valid
`ifdef UNDERRUN_CNT_EN
        , output underrun_cnt
`endif
    );

    modport slave (
        output key2, rec_valid, rec_end_addr, sample_req, rd_ack, rd_data,
        input  rd_req, rd_addr, sdr_raddr_set, play_start, playing, dac_data, dac_valid
`ifdef UNDERRUN_CNT_EN
        , input underrun_cnt
`endif
    );

endinterface

// File: rtl/play_ctrl_debounce.sv
// Active-low key debouncer: one single-cycle press event per physical press.
module key_debounce
    import play_ctrl_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic press_o
);

    localparam logic [16:0] CNT_MATCH = {1'b0, DEBOUNCE_CNT};
    localparam logic [16:0] CNT_SAT   = CNT_MATCH + 17'd1;

    logic [16:0] cnt_q, cnt_d;

    // Saturating one past the match value is what keeps a long press to one event.
    always_comb begin
        cnt_d = cnt_q;
        if (key_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 17'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign press_o = (cnt_q == CNT_MATCH) && ((DEBOUNCE_CNT != 16'd0) || !key_i);

endmodule

// File: rtl/play_ctrl.sv
// Playback controller: key-started SDRAM readout paced by DAC sample requests.
// UNDERRUN_CNT_EN adds a saturating count of sample requests dropped while a read is pending.
module play_ctrl
    import play_ctrl_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int          ADDR_W       = ADDR_W_DEF
) (
    input  logic        clk50M,
    input  logic        reset_n,
    play_ctrl_if.master bus
);

    play_state_e       state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [15:0]       dac_data_q, dac_data_d;
    logic              dac_valid_q, dac_valid_d;
    logic              press;

    key_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_debounce (
        .clk_i  (clk50M),
        .rst_ni (reset_n),
        .key_i  (bus.key2),
        .press_o(press)
    );

    // A press while playing wins over rd_ack, so aborted data never reaches the DAC.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        dac_data_d  = dac_data_q;
        dac_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press && bus.rec_valid) begin
                    state_d   = ADDR_SET;
                    rd_addr_d = '0;
                end
            end
            ADDR_SET: begin
                rd_addr_d = '0;
                state_d   = WAIT_REQ;
            end
            WAIT_REQ: begin
                if (press) begin
                    state_d = IDLE;
                end else if (bus.sample_req) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (press) begin
                    state_d = IDLE;
                end else if (bus.rd_ack) begin
                    dac_data_d  = bus.rd_data;
                    dac_valid_d = 1'b1;
                    if (rd_addr_q == bus.rec_end_addr) begin
                        state_d = IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        state_d   = WAIT_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            dac_data_q  <= '0;
            dac_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            dac_data_q  <= dac_data_d;
            dac_valid_q <= dac_valid_d;
        end
    end

    assign bus.rd_req        = (state_q == READ);
    assign bus.playing       = (state_q != IDLE);
    assign bus.sdr_raddr_set = (state_q == IDLE);
    assign bus.play_start    = (state_q == ADDR_SET);
    assign bus.rd_addr       = rd_addr_q;
    assign bus.dac_data      = dac_data_q;
    assign bus.dac_valid     = dac_valid_q;

`ifdef UNDERRUN_CNT_EN
    logic [15:0] underrun_q, underrun_d;

    always_comb begin
        underrun_d = underrun_q;
        if (state_q == IDLE && state_d == ADDR_SET) begin
            underrun_d = '0;
        end else if (state_q == READ && bus.sample_req && underrun_q != 16'hFFFF) begin
            underrun_d = underrun_q + 16'd1;
        end
    end

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            underrun_q <= '0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign bus.underrun_cnt = underrun_q;
`endif

endmodule

// File: tb/tb_play_ctrl.sv
// Scoreboard bench for play_ctrl: expected DAC samples are queued when rd_ack is driven.
module tb_play_ctrl;
    import play_ctrl_pkg::*;

    localparam int ADDR_W = ADDR_W_DEF;
    localparam int CNT    = 32'h0351;
    localparam int GAP    = 990;

    logic clk = 1'b0;
    logic rstN;

    play_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    play_ctrl #(
        .DEBOUNCE_CNT(16'h0351),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk50M (clk),
        .reset_n(rstN),
        .bus    (bus)
    );

    always #10 clk = ~clk;

    int          checkCount = 0;
    int          passCount  = 0;
    int          dacCount   = 0;
    logic [15:0] sb[$];
    logic [15:0] samples[4] = '{16'h1234, 16'hBEEF, 16'h0001, 16'hFFFF};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pressKey(input int n);
        bus.key2 = 1'b0;
        repeat (n) tick();
        bus.key2 = 1'b1;
    endtask

    // One sample: request, optional dropped request mid-read, then rd_ack with data.
    task automatic applyStimulus(input logic [15:0] data, input int expAddr, input bit extraReq);
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        checkOutput("rdReqRise", bus.rd_req, 1);
        checkOutput("rdAddr", bus.rd_addr, expAddr);
        if (extraReq) begin
            bus.sample_req = 1'b1;
            tick();
            bus.sample_req = 1'b0;
            repeat (3) tick();
        end else begin
            repeat (4) tick();
        end
        bus.rd_ack  = 1'b1;
        bus.rd_data = data;
        sb.push_back(data);
        tick();
        bus.rd_ack = 1'b0;
        checkOutput("rdReqDrop", bus.rd_req, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.dac_valid === 1'b1) begin
            dacCount++;
            if (sb.size() == 0) begin
                checkOutput("dacValidUnexpected", bus.dac_valid, 0);
            end else begin
                checkOutput("dacData", bus.dac_data, sb.pop_front());
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN             = 1'b0;
        bus.key2         = 1'b1;
        bus.rec_valid    = 1'b0;
        bus.rec_end_addr = ADDR_W'(3);
        bus.sample_req   = 1'b0;
        bus.rd_ack       = 1'b0;
        bus.rd_data      = '0;
        repeat (3) tick();
        checkOutput("rstPlaying", bus.playing, 0);
        checkOutput("rstRdReq", bus.rd_req, 0);
        checkOutput("rstRaddrSet", bus.sdr_raddr_set, 1);
        checkOutput("rstPlayStart", bus.play_start, 0);
        checkOutput("rstDacValid", bus.dac_valid, 0);
        checkOutput("rstRdAddr", bus.rd_addr, 0);
        checkOutput("rstDacData", bus.dac_data, 0);
        rstN = 1'b1;
        tick();

        bus.rec_valid = 1'b1;
        pressKey(32'h300);
        repeat (5) tick();
        checkOutput("shortPressIdle", bus.playing, 0);
        checkOutput("shortPressRaddrSet", bus.sdr_raddr_set, 1);

        bus.rec_valid = 1'b0;
        pressKey(CNT + 16);
        repeat (3) tick();
        checkOutput("noRecIdle", bus.playing, 0);

        bus.rec_valid = 1'b1;
        bus.key2      = 1'b0;
        repeat (CNT - 1) tick();
        checkOutput("noEarlyStart", bus.play_start, 0);
        tick();
        bus.key2 = 1'b1;
        checkOutput("noStartAtPress", bus.play_start, 0);
        tick();
        checkOutput("playStart", bus.play_start, 1);
        checkOutput("raddrSetFall", bus.sdr_raddr_set, 0);
        checkOutput("playingOn", bus.playing, 1);
        tick();
        checkOutput("playStartPulse", bus.play_start, 0);
        checkOutput("waitReqRdReq", bus.rd_req, 0);
        checkOutput("waitReqPlaying", bus.playing, 1);

        bus.rec_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (GAP) tick();
            applyStimulus(samples[i], i, 1'b0);
        end
        checkOutput("endIdlePlaying", bus.playing, 0);
        checkOutput("endIdleRaddrSet", bus.sdr_raddr_set, 1);
        tick();
        checkOutput("dacCount4", dacCount, 4);
        checkOutput("sbDrained", sb.size(), 0);

        bus.rec_valid = 1'b1;
        pressKey(CNT);
        tick();
        checkOutput("playStart2", bus.play_start, 1);
        tick();
        repeat (5) tick();
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        checkOutput("readEntered", bus.rd_req, 1);
        for (int k = 0; k < 3; k++) begin
            repeat (2) tick();
            bus.sample_req = 1'b1;
            tick();
            bus.sample_req = 1'b0;
        end
`ifdef UNDERRUN_CNT_EN
        checkOutput("underrun3", bus.underrun_cnt, 3);
`endif
        checkOutput("underrunStillRead", bus.rd_req, 1);

        bus.key2 = 1'b0;
        repeat (CNT) tick();
        bus.rd_ack  = 1'b1;
        bus.rd_data = 16'hDEAD;
        tick();
        bus.rd_ack = 1'b0;
        bus.key2   = 1'b1;
        checkOutput("abortPlaying", bus.playing, 0);
        checkOutput("abortRdReq", bus.rd_req, 0);
        checkOutput("abortRaddrSet", bus.sdr_raddr_set, 1);
        checkOutput("abortDacValid", bus.dac_valid, 0);
        tick();
        checkOutput("abortNoDacLater", bus.dac_valid, 0);
`ifdef UNDERRUN_CNT_EN
        checkOutput("underrunHold", bus.underrun_cnt, 3);
`endif

        pressKey(CNT);
        tick();
        checkOutput("playStart3", bus.play_start, 1);
`ifdef UNDERRUN_CNT_EN
        checkOutput("underrunClear", bus.underrun_cnt, 0);
`endif
        tick();
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        checkOutput("preRstRdReq", bus.rd_req, 1);
        #5;
        rstN = 1'b0;
        #1;
        checkOutput("asyncRstRdReq", bus.rd_req, 0);
        checkOutput("asyncRstPlaying", bus.playing, 0);
        checkOutput("asyncRstRaddrSet", bus.sdr_raddr_set, 1);
        checkOutput("asyncRstRdAddr", bus.rd_addr, 0);
        checkOutput("asyncRstDacData", bus.dac_data, 0);
        checkOutput("asyncRstDacValid", bus.dac_valid, 0);

        bus.key2         = 1'b0;
        bus.rec_end_addr = ADDR_W'(1);
        repeat (2) tick();
        rstN = 1'b1;
        repeat (CNT) tick();
        checkOutput("postRstNoEarly", bus.playing, 0);
        tick();
        bus.key2 = 1'b1;
        checkOutput("postRstPlayStart", bus.play_start, 1);
        tick();

        applyStimulus(16'h1111, 0, 1'b1);
        checkOutput("waitAfterUnderrun", bus.playing, 1);
        repeat (10) tick();
        checkOutput("noQueuedReq", bus.rd_req, 0);
        applyStimulus(16'h2222, 1, 1'b0);
        checkOutput("endIdle2Playing", bus.playing, 0);
        checkOutput("endIdle2RaddrSet", bus.sdr_raddr_set, 1);
        repeat (2) tick();
        checkOutput("sbDrainedFinal", sb.size(), 0);
        checkOutput("dacCountFinal", dacCount, 6);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/play_ctrl.md
PLAY_CTRL -- requirements
Module: play_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CNT, default 16'h0351, key-low cycles before a press is accepted.
REQ-002 The block SHALL have parameter ADDR_W, default 22, the SDRAM sample address width.
REQ-003 clk50M  in  1  system clock; all logic SHALL be on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 key2  in  1  play key, active-low, already synchronised.
REQ-006 rec_valid  in  1  a completed recording exists.
REQ-007 rec_end_addr  in  ADDR_W  last sample address written by the record path.
REQ-008 sample_req  in  1  one-cycle pulse from the DAC side requesting the next sample.
REQ-009 rd_req  out  1  read request to the SDRAM read port.
REQ-010 rd_ack  in  1  read data valid on rd_data this cycle.
REQ-011 rd_data  in  16  sample read from SDRAM.
REQ-012 rd_addr  out  ADDR_W  current read address.
REQ-013 sdr_raddr_set  out  1  hold SDRAM read address at 0.
REQ-014 play_start  out  1  one-cycle pulse at start of playback.
REQ-015 playing  out  1  high while playback is active.
REQ-016 dac_data  out  16  sample to the DAC.
REQ-017 dac_valid  out  1  one-cycle strobe when dac_data updates.

Function
REQ-018 The debounce counter SHALL clear while key2=1, increment while key2=0, and saturate at DEBOUNCE_CNT+1.
REQ-019 A press event SHALL be a single cycle, generated in the cycle the counter equals DEBOUNCE_CNT, with exactly one event per physical press.
REQ-020 The FSM SHALL have the states IDLE, ADDR_SET, WAIT_REQ and READ.
REQ-021 In IDLE, the block SHALL drive playing=0, rd_req=0 and sdr_raddr_set=1.
REQ-022 In IDLE, a press event with rec_valid=1 SHALL move the FSM to ADDR_SET.
REQ-023 In IDLE, a press event with rec_valid=0 SHALL be ignored.
REQ-024 ADDR_SET SHALL last one cycle: it sets rd_addr to 0, deasserts sdr_raddr_set, pulses play_start and goes to WAIT_REQ.
REQ-025 In WAIT_REQ and READ, the block SHALL drive playing=1.
REQ-026 In WAIT_REQ, sample_req SHALL move the FSM to READ with rd_req=1 registered in the same edge.
REQ-027 In READ, rd_req SHALL stay high until the cycle rd_ack=1, then drop on the next edge.
REQ-028 On the rd_ack edge, the block SHALL register dac_data<=rd_data and assert dac_valid for exactly one cycle; latency rd_ack to dac_valid SHALL be one cycle.
REQ-029 On the rd_ack edge, if rd_addr==rec_end_addr the FSM SHALL go to IDLE, otherwise rd_addr SHALL increment by 1 and the FSM SHALL go to WAIT_REQ.
REQ-030 A press event in WAIT_REQ or READ SHALL abort playback to IDLE on the next edge, overriding a simultaneous rd_ack; a pending rd_req SHALL drop and the data SHALL be discarded.
REQ-031 A sample_req in READ SHALL be dropped (underrun); the FSM SHALL not queue it.
REQ-032 rd_addr arithmetic SHALL be modulo 2^ADDR_W; with rec_end_addr=all-ones, end detection SHALL occur before the wrap.
REQ-033 A change of rec_valid during playback SHALL have no effect.

Reset
REQ-034 reset_n=0 SHALL asynchronously force the FSM to IDLE with: debounce counter 0, rd_addr 0, dac_data 0, rd_req 0, play_start 0, playing 0, dac_valid 0 and sdr_raddr_set 1.
REQ-035 Reset during READ SHALL drop rd_req immediately; the first post-reset press with key2 held SHALL require a full DEBOUNCE_CNT count.

Configuration
REQ-036 With UNDERRUN_CNT_EN defined, the block SHALL add output underrun_cnt (16 bits) that increments per REQ-031 event, saturates at 16'hFFFF and clears at play_start.
REQ-037 Without UNDERRUN_CNT_EN, the port and its counter SHALL be absent and the rest of the behaviour SHALL be identical.

Structure
REQ-038 A shared package SHALL hold the FSM state enum, the default DEBOUNCE_CNT and the default ADDR_W.
REQ-039 Debounce SHALL be a sub-module key_debounce (key, press-event out), reusable by the record path.

Verification
REQ-040 Hold key2=0 for 0x351 cycles with rec_valid=1 -> play_start pulse 0x352 cycles after the fall, sdr_raddr_set falls, playing=1.
REQ-041 Key2 low for 0x300 cycles then high -> no event, FSM stays in IDLE.
REQ-042 rec_end_addr=3, sample_req every 1000 cycles, rd_ack 5 cycles after rd_req -> 4 dac_valid pulses with the rd_data values, then IDLE with sdr_raddr_set=1.
REQ-043 Second press during READ coinciding with rd_ack -> IDLE next cycle, no dac_valid.
REQ-044 With UNDERRUN_CNT_EN, 3 sample_req pulses while rd_ack is withheld -> underrun_cnt=3; it clears on the next play_start.
REQ-045 reset_n low mid-READ -> rd_req and playing low asynchronously, outputs at their reset values.
